// File: rtl/tetris_move_sched_pkg.sv
// Shared constants, state encoding and position type for the active-piece sequencer.
package tetris_move_sched_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;
    localparam int TYPE_W  = 2;

    localparam logic [X_W-1:0] SPAWN_X = X_W'(4);
    localparam logic [Y_W-1:0] SPAWN_Y = Y_W'(0);

    // Bit positions of the pending-move vector; lower index wins arbitration.
    localparam int IDX_DOWN  = 0;
    localparam int IDX_ROT   = 1;
    localparam int IDX_LEFT  = 2;
    localparam int IDX_RIGHT = 3;

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_SCHK,
        ST_IDLE,
        ST_MCHK,
        ST_LOCK,
        ST_OVER
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [1:0]     rot;
    } pos_t;

    localparam pos_t SPAWN_POS = '{x: SPAWN_X, y: SPAWN_Y, rot: 2'd0};

endpackage

// File: rtl/tetris_move_sched_if.sv
// Spawn, collision-check and lock handshakes between the sequencer and the board side.
interface tetris_move_sched_if;
    import tetris_move_sched_pkg::*;

    logic              spawn_take;
    logic [TYPE_W-1:0] next_type;
    logic              chk_req;
    logic [X_W-1:0]    chk_x;
    logic [Y_W-1:0]    chk_y;
    logic [1:0]        chk_rot;
    logic [TYPE_W-1:0] chk_type;
    logic              chk_ack;
    logic              chk_hit;
    logic              lock_req;
    logic              lock_done;

    modport master (
        output spawn_take, chk_req, chk_x, chk_y, chk_rot, chk_type, lock_req,
        input  next_type, chk_ack, chk_hit, lock_done
    );

    modport slave (
        input  spawn_take, chk_req, chk_x, chk_y, chk_rot, chk_type, lock_req,
        output next_type, chk_ack, chk_hit, lock_done
    );

endinterface

// File: rtl/tetris_move_arb.sv
// Sticky move-pending bits, fixed-priority grant and candidate position with bounds pre-check.
module tetris_move_arb
    import tetris_move_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mv_rotate,
    input  logic mv_left,
    input  logic mv_right,
    input  logic down_in,
    input  logic sw_pause,
    input  logic grant_en,
    input  logic clr_all,
    input  pos_t cur,
    output logic gnt,
    output logic gnt_down,
    output logic gnt_reject,
    output pos_t cand
);

    logic [3:0] pend_q;
    logic [3:0] win;

    // Pick one pending move (down > rotate > left > right) and form its candidate.
    always_comb begin
        win        = '0;
        gnt_down   = 1'b0;
        gnt_reject = 1'b0;
        cand       = cur;
        if (grant_en) begin
            if (pend_q[IDX_DOWN]) begin
                win[IDX_DOWN] = 1'b1;
                gnt_down      = 1'b1;
                gnt_reject    = (cur.y == Y_W'(BOARD_H - 1));
                cand.y        = cur.y + Y_W'(1);
            end else if (pend_q[IDX_ROT]) begin
                win[IDX_ROT] = 1'b1;
                cand.rot     = cur.rot + 2'd1;
            end else if (pend_q[IDX_LEFT]) begin
                win[IDX_LEFT] = 1'b1;
                gnt_reject    = (cur.x == '0);
                cand.x        = cur.x - X_W'(1);
            end else if (pend_q[IDX_RIGHT]) begin
                win[IDX_RIGHT] = 1'b1;
                gnt_reject     = (cur.x == X_W'(BOARD_W - 1));
                cand.x         = cur.x + X_W'(1);
            end
        end
        gnt = |win;
    end

    // Winner clears before new pulses are OR-ed in, so a same-cycle pulse survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else if (sw_pause || clr_all) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~win) | {mv_right, mv_left, mv_rotate, down_in};
        end
    end

endmodule

// File: rtl/tetris_move_sched.sv
// Active-piece sequencer: spawn, move arbitration, collision handshake, lock and game over.
module tetris_move_sched
    import tetris_move_sched_pkg::*;
(
    input  logic                board_clk,
    input  logic                btn_rst,
    input  logic                mv_rotate,
    input  logic                mv_left,
    input  logic                mv_right,
    input  logic                mv_down,
    input  logic                grav_tick,
    input  logic                sw_drop,
    input  logic                sw_pause,
    tetris_move_sched_if.master bus,
    output logic [X_W-1:0]      cur_x,
    output logic [Y_W-1:0]      cur_y,
    output logic [1:0]          cur_rot,
    output logic [TYPE_W-1:0]   cur_type,
    output logic                game_over
);

    state_t            state_q, state_d;
    pos_t              cur_q, cand_q, arb_cand;
    logic [TYPE_W-1:0] type_q;
    logic              cand_down_q, take_q;
    logic              gnt, gnt_down, gnt_reject;
    logic              grant_en, clr_all, load_spawn, launch, commit, ack_ok;

    assign grant_en = (state_q == ST_IDLE) && !sw_pause;
    assign ack_ok   = bus.chk_req && bus.chk_ack;

    tetris_move_arb u_arb (
        .clk        (board_clk),
        .rst_n      (btn_rst),
        .mv_rotate  (mv_rotate),
        .mv_left    (mv_left),
        .mv_right   (mv_right),
        .down_in    (mv_down | grav_tick | sw_drop),
        .sw_pause   (sw_pause),
        .grant_en   (grant_en),
        .clr_all    (clr_all),
        .cur        (cur_q),
        .gnt        (gnt),
        .gnt_down   (gnt_down),
        .gnt_reject (gnt_reject),
        .cand       (arb_cand)
    );

    // State register.
    always_ff @(posedge board_clk or negedge btn_rst) begin
        if (!btn_rst) state_q <= ST_SPAWN;
        else          state_q <= state_d;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d    = state_q;
        clr_all    = 1'b0;
        load_spawn = 1'b0;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_SPAWN: begin
                load_spawn = 1'b1;
                state_d    = ST_SCHK;
            end
            ST_SCHK: if (ack_ok) state_d = bus.chk_hit ? ST_OVER : ST_IDLE;
            ST_IDLE: begin
                if (gnt && !gnt_reject) begin
                    launch  = 1'b1;
                    state_d = ST_MCHK;
                end else if (gnt && gnt_down) begin
                    clr_all = 1'b1;
                    state_d = ST_LOCK;
                end
            end
            ST_MCHK: begin
                if (ack_ok) begin
                    if (!bus.chk_hit) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cand_down_q) begin
                        clr_all = 1'b1;
                        state_d = ST_LOCK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCK: if (bus.lock_done) state_d = ST_SPAWN;
            ST_OVER: clr_all = 1'b1;
            default: state_d = ST_SPAWN;
        endcase
    end

    // Position, candidate and type registers; spawn_take is the registered SPAWN visit.
    always_ff @(posedge board_clk or negedge btn_rst) begin
        if (!btn_rst) begin
            cur_q       <= SPAWN_POS;
            cand_q      <= SPAWN_POS;
            type_q      <= '0;
            cand_down_q <= 1'b0;
            take_q      <= 1'b0;
        end else begin
            take_q <= load_spawn;
            if (load_spawn) begin
                cur_q  <= SPAWN_POS;
                cand_q <= SPAWN_POS;
                type_q <= bus.next_type;
            end
            if (launch) begin
                cand_q      <= arb_cand;
                cand_down_q <= gnt_down;
            end
            if (commit) cur_q <= cand_q;
        end
    end

    // Handshake levels follow the state directly.
    always_comb begin
        bus.chk_req  = (state_q == ST_SCHK) || (state_q == ST_MCHK);
        bus.lock_req = (state_q == ST_LOCK);
        game_over    = (state_q == ST_OVER);
    end

    assign bus.spawn_take = take_q;
    assign bus.chk_x      = cand_q.x;
    assign bus.chk_y      = cand_q.y;
    assign bus.chk_rot    = cand_q.rot;
    assign bus.chk_type   = type_q;
    assign cur_x          = cur_q.x;
    assign cur_y          = cur_q.y;
    assign cur_rot        = cur_q.rot;
    assign cur_type       = type_q;

endmodule
